// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter sharing one generic bus slave between an instruction (i_) and a data (d_) requestor
// Ports:
//   CLK, RST                                  clock, synchronous active-high reset
//   i_/d_addr, ren, wen, wdata, byte_en       requestor command inputs (held until busy=0)
//   i_/d_rdata, busy, error                   requestor responses; busy=0 marks completion
//   m_addr, m_ren, m_wen, m_wdata, m_byte_en  command toward the slave (grantee's inputs, else 0)
//   m_rdata, m_busy, m_error                  slave response, routed only to the grantee
module bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_ren,
    input  logic                i_wen,
    input  logic [WORD_W-1:0]   i_wdata,
    input  logic [WORD_W/8-1:0] i_byte_en,
    output logic [WORD_W-1:0]   i_rdata,
    output logic                i_busy,
    output logic                i_error,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic                d_ren,
    input  logic                d_wen,
    input  logic [WORD_W-1:0]   d_wdata,
    input  logic [WORD_W/8-1:0] d_byte_en,
    output logic [WORD_W-1:0]   d_rdata,
    output logic                d_busy,
    output logic                d_error,
    output logic [ADDR_W-1:0]   m_addr,
    output logic                m_ren,
    output logic                m_wen,
    output logic [WORD_W-1:0]   m_wdata,
    output logic [WORD_W/8-1:0] m_byte_en,
    input  logic [WORD_W-1:0]   m_rdata,
    input  logic                m_busy,
    input  logic                m_error
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
    state_t r_state, w_next;
    logic   r_last_d, w_next_last_d;
    logic   w_i_req, w_d_req, w_si, w_sd;
    assign w_i_req = i_ren | i_wen;
    assign w_d_req = d_ren | d_wen;
    // outputs are forced to their idle values while RST is high so an aborted transfer never completes
    assign w_si = (r_state == SERVE_I) & ~RST;
    assign w_sd = (r_state == SERVE_D) & ~RST;
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_last_d <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_last_d <= w_next_last_d;
        end
    end
    always_comb begin
        w_next        = IDLE;
        w_next_last_d = r_last_d;
        case (r_state)
            IDLE: begin
                // on a tie, D wins unless it had the last grant
                w_next        = (w_d_req & (~w_i_req | ~r_last_d)) ? SERVE_D : w_i_req ? SERVE_I : IDLE;
                w_next_last_d = (w_next == IDLE) ? r_last_d : (w_next == SERVE_D);
            end
            SERVE_I: w_next = (w_i_req & m_busy) ? SERVE_I : IDLE;
            SERVE_D: w_next = (w_d_req & m_busy) ? SERVE_D : IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        m_addr    = w_si ? i_addr    : w_sd ? d_addr    : '0;
        m_ren     = w_si ? i_ren     : w_sd ? d_ren     : 1'b0;
        m_wen     = w_si ? i_wen     : w_sd ? d_wen     : 1'b0;
        m_wdata   = w_si ? i_wdata   : w_sd ? d_wdata   : '0;
        m_byte_en = w_si ? i_byte_en : w_sd ? d_byte_en : '0;
        // a grantee that dropped its request gets no completion pulse
        i_busy    = w_si ? (~w_i_req | m_busy) : 1'b1;
        d_busy    = w_sd ? (~w_d_req | m_busy) : 1'b1;
        i_rdata   = w_si ? m_rdata : '0;
        d_rdata   = w_sd ? m_rdata : '0;
        i_error   = w_si & m_error;
        d_error   = w_sd & m_error;
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and randomized checks of bus_arbiter against a transaction-rule reference model
module tb_bus_arbiter;
    localparam int AW = 32;
    localparam int WW = 32;
    localparam int BW = WW / 8;
    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [AW-1:0] i_addr, d_addr, m_addr;
    logic          i_ren, i_wen, d_ren, d_wen, m_ren, m_wen;
    logic [WW-1:0] i_wdata, d_wdata, m_wdata, i_rdata, d_rdata, m_rdata;
    logic [BW-1:0] i_byte_en, d_byte_en, m_byte_en;
    logic          i_busy, d_busy, i_error, d_error, m_busy, m_error;
    int tests = 0;
    int fails = 0;
    // reference model: who is being served (0 none, 1 I, 2 D) and who got the last grant (1 I, 2 D)
    int serving = 0;
    int last = 1;
    int nxt_s = 0;
    int nxt_l = 1;
    int g;
    bit ir, dr, gr;
    bit ip = 0, dp = 0, idone = 0, ddone = 0;
    int n;
    logic [63:0] exp_a;

    bus_arbiter #(.ADDR_W(AW), .WORD_W(WW)) dut (
        .CLK(CLK), .RST(RST),
        .i_addr(i_addr), .i_ren(i_ren), .i_wen(i_wen), .i_wdata(i_wdata), .i_byte_en(i_byte_en),
        .i_rdata(i_rdata), .i_busy(i_busy), .i_error(i_error),
        .d_addr(d_addr), .d_ren(d_ren), .d_wen(d_wen), .d_wdata(d_wdata), .d_byte_en(d_byte_en),
        .d_rdata(d_rdata), .d_busy(d_busy), .d_error(d_error),
        .m_addr(m_addr), .m_ren(m_ren), .m_wen(m_wen), .m_wdata(m_wdata), .m_byte_en(m_byte_en),
        .m_rdata(m_rdata), .m_busy(m_busy), .m_error(m_error)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nc();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        #2;
    endtask

    always @(negedge CLK) begin
        ir = i_ren | i_wen;
        dr = d_ren | d_wen;
        g  = RST ? 0 : serving;
        chk("m_addr",    m_addr,    g == 1 ? i_addr    : g == 2 ? d_addr    : '0);
        chk("m_ren",     m_ren,     g == 1 ? i_ren     : g == 2 ? d_ren     : 1'b0);
        chk("m_wen",     m_wen,     g == 1 ? i_wen     : g == 2 ? d_wen     : 1'b0);
        chk("m_wdata",   m_wdata,   g == 1 ? i_wdata   : g == 2 ? d_wdata   : '0);
        chk("m_byte_en", m_byte_en, g == 1 ? i_byte_en : g == 2 ? d_byte_en : '0);
        chk("i_busy",    i_busy,    g == 1 ? (!ir || m_busy) : 1'b1);
        chk("d_busy",    d_busy,    g == 2 ? (!dr || m_busy) : 1'b1);
        chk("i_rdata",   i_rdata,   g == 1 ? m_rdata : '0);
        chk("d_rdata",   d_rdata,   g == 2 ? m_rdata : '0);
        chk("i_error",   i_error,   g == 1 ? m_error : 1'b0);
        chk("d_error",   d_error,   g == 2 ? m_error : 1'b0);
        if (RST) begin
            nxt_s = 0;
            nxt_l = 1;
        end else if (serving == 0) begin
            nxt_s = (ir && dr) ? 3 - last : ir ? 1 : dr ? 2 : 0;
            nxt_l = (nxt_s != 0) ? nxt_s : last;
        end else begin
            gr    = (serving == 1) ? ir : dr;
            nxt_s = (gr && m_busy) ? serving : 0;
            nxt_l = last;
        end
    end

    always @(posedge CLK) begin
        serving = nxt_s;
        last    = nxt_l;
    end

    initial begin
        i_addr = '0; i_ren = 0; i_wen = 0; i_wdata = '0; i_byte_en = '0;
        d_addr = '0; d_ren = 0; d_wen = 0; d_wdata = '0; d_byte_en = '0;
        m_rdata = '0; m_busy = 0; m_error = 0;
        repeat (2) @(posedge CLK);
        #1 RST = 0;
        smp();
        chk("post_rst_busy", {i_busy, d_busy}, 2'b11);
        chk("post_rst_mren", m_ren, 0);
        // single read
        nc(); d_ren = 1; d_addr = 'h100; m_busy = 0; m_rdata = 'hDEADBEEF;
        smp(); chk("rd_req_busy", d_busy, 1); chk("rd_req_mren", m_ren, 0);
        nc(); smp();
        chk("rd_maddr", m_addr, 'h100); chk("rd_mren", m_ren, 1);
        chk("rd_dbusy", d_busy, 0); chk("rd_rdata", d_rdata, 'hDEADBEEF);
        nc(); d_ren = 0;
        smp(); chk("rd_idle_busy", d_busy, 1); chk("rd_idle_mren", m_ren, 0);
        // tie right after reset: D first, then I after one bubble
        nc(); RST = 1;
        nc(); RST = 0; i_ren = 1; i_addr = 'h200; d_wen = 1; d_addr = 'h300; d_wdata = 'h12345678; d_byte_en = 'hF;
        nc(); smp();
        chk("tie_mwen", m_wen, 1); chk("tie_mwdata", m_wdata, 'h12345678); chk("tie_maddr", m_addr, 'h300);
        chk("tie_mbe", m_byte_en, 'hF); chk("tie_ibusy", i_busy, 1); chk("tie_dbusy", d_busy, 0);
        nc(); d_wen = 0;
        smp(); chk("tie_bubble", {m_ren, m_wen}, 0); chk("tie_bubble_ibusy", i_busy, 1);
        nc(); smp();
        chk("tie_i_maddr", m_addr, 'h200); chk("tie_i_mren", m_ren, 1); chk("tie_i_busy", i_busy, 0);
        nc(); i_ren = 0;
        // wait states: D granted (last was I), slave busy for three cycles
        d_ren = 1; d_addr = 'h400; i_ren = 1; i_addr = 'h500; m_busy = 1;
        for (int k = 0; k < 3; k++) begin
            nc(); smp();
            chk("ws_dbusy", d_busy, 1); chk("ws_ibusy", i_busy, 1); chk("ws_maddr", m_addr, 'h400);
        end
        nc(); m_busy = 0;
        smp(); chk("ws_dbusy_done", d_busy, 0); chk("ws_ibusy_done", i_busy, 1);
        nc(); d_ren = 0;
        smp(); chk("ws_bubble", i_busy, 1);
        nc(); smp(); chk("ws_i_maddr", m_addr, 'h500); chk("ws_i_busy", i_busy, 0);
        nc(); i_ren = 0;
        // alternation under continuous requests
        i_ren = 1; d_ren = 1; i_addr = 'h1000; d_addr = 'h2000; n = 0;
        for (int k = 0; k < 12; k++) begin
            smp();
            if (m_ren) begin
                exp_a = (n % 2 == 0) ? 'h2000 : 'h1000;
                chk("alt_grant", m_addr, exp_a);
                n++;
            end
            nc();
        end
        chk("alt_count", n, 6);
        i_ren = 0; d_ren = 0;
        // reset during SERVE_I with the slave stalled
        nc(); i_ren = 1; i_addr = 'h600; m_busy = 1;
        nc(); smp(); chk("rst_pre_ibusy", i_busy, 1); chk("rst_pre_mren", m_ren, 1);
        RST = 1; #1 chk("rst_during_mren", m_ren, 0);
        nc(); RST = 0;
        smp(); chk("rst_mren", m_ren, 0); chk("rst_busy", {i_busy, d_busy}, 2'b11);
        i_ren = 0;
        // reset during SERVE_D restores last_grant=I, so D wins the following tie
        nc(); d_ren = 1; d_addr = 'h700; m_busy = 1;
        nc(); RST = 1; m_busy = 0;
        smp(); chk("rst_abort_dbusy", d_busy, 1);
        nc(); RST = 0; i_ren = 1; i_addr = 'h800;
        smp(); chk("rst_idle_mren", m_ren, 0);
        nc(); smp(); chk("rst_tie_maddr", m_addr, 'h700); chk("rst_tie_dbusy", d_busy, 0);
        nc(); d_ren = 0;
        nc(); smp(); chk("rst_tie_i_maddr", m_addr, 'h800); chk("rst_tie_ibusy", i_busy, 0);
        nc(); i_ren = 0;
        // error forwarded to the grantee only
        nc(); i_ren = 1; i_addr = 'h900; m_error = 1; m_busy = 0;
        nc(); smp(); chk("err_ierr", i_error, 1); chk("err_ibusy", i_busy, 0); chk("err_derr", d_error, 0);
        nc(); i_ren = 0; m_error = 0;
        smp(); chk("err_clear", i_error, 0);
        // grantee drops its request mid-wait
        nc(); i_wen = 1; i_addr = 'hA00; m_busy = 1;
        nc(); smp(); chk("ab_wait_ibusy", i_busy, 1); chk("ab_wait_mwen", m_wen, 1);
        nc(); i_wen = 0; m_busy = 0;
        smp(); chk("ab_drop_ibusy", i_busy, 1); chk("ab_drop_mwen", m_wen, 0);
        nc(); smp(); chk("ab_idle_ibusy", i_busy, 1);
        // randomized traffic checked cycle by cycle by the model
        repeat (3000) begin
            nc();
            if (RST) begin
                ip = 0; dp = 0;
            end else begin
                if (ip && (idone || $urandom_range(19) == 0)) ip = 0;
                else if (!ip && $urandom_range(1) == 1) begin
                    ip = 1;
                    i_addr = $urandom; i_wdata = $urandom; i_byte_en = BW'($urandom);
                    {i_ren, i_wen} = ($urandom_range(7) == 0) ? 2'b11 : ($urandom_range(1) == 1) ? 2'b10 : 2'b01;
                end
                if (dp && (ddone || $urandom_range(19) == 0)) dp = 0;
                else if (!dp && $urandom_range(1) == 1) begin
                    dp = 1;
                    d_addr = $urandom; d_wdata = $urandom; d_byte_en = BW'($urandom);
                    {d_ren, d_wen} = ($urandom_range(7) == 0) ? 2'b11 : ($urandom_range(1) == 1) ? 2'b10 : 2'b01;
                end
            end
            if (!ip) begin i_ren = 0; i_wen = 0; i_addr = $urandom; end
            if (!dp) begin d_ren = 0; d_wen = 0; d_addr = $urandom; end
            RST = ($urandom_range(99) == 0);
            m_busy = ($urandom_range(2) == 0);
            m_rdata = $urandom;
            m_error = ($urandom_range(7) == 0);
            smp();
            idone = !i_busy;
            ddone = !d_busy;
        end
        nc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
